// File: rtl/seq_mul_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Brief    : Shared FSM state type and counter sizing for the sequential multiplier.
// Revision : 1.0
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // The step counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/seq_mul_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_mul_unit_if
// Brief    : Operand load, start/busy/done handshake and result bus of the multiplier.
// Revision : 1.0
// ============================================================================
interface seq_mul_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   din;
    logic               load_a;
    logic               load_b;
    logic               start;
    logic               signed_md;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;

    modport master (
        output din, load_a, load_b, start, signed_md,
        input  busy, done, result, op_a, op_b
    );

    modport slave (
        input  din, load_a, load_b, start, signed_md,
        output busy, done, result, op_a, op_b
    );
endinterface
`default_nettype wire

// File: rtl/seq_mul_unit_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_mul_core
// Brief    : Unsigned shift-add datapath: one partial product per step.
// Revision : 1.0
// ============================================================================
module seq_mul_core #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   w_addend;

    assign w_addend = {{WIDTH{1'b0}}, mcand_q} << cnt_q;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + w_addend;
            end
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product_o = acc_q;
    assign cnt_o     = cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_mul_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_mul_unit
// Brief    : Sequential signed/unsigned multiplier with operand registers and handshake.
// Revision : 1.0
// ============================================================================
module seq_mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit HOLD_RES = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mul_unit_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_b_q;
    logic [2*WIDTH-1:0] result_q;
    logic               done_q;
    logic               neg_q;

    logic               w_core_load, w_core_step;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_core_prod, w_final;
    logic [CW-1:0]      w_cnt;

    // The core always multiplies magnitudes; the sign is re-applied at completion.
    assign w_mag_a = (bus.signed_md && op_a_q[WIDTH-1]) ? -op_a_q : op_a_q;
    assign w_mag_b = (bus.signed_md && op_b_q[WIDTH-1]) ? -op_b_q : op_b_q;
    assign w_neg   = bus.signed_md & (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]);
    assign w_final = neg_q ? -w_core_prod : w_core_prod;

    seq_mul_core #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CW)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (w_core_load),
        .step_i    (w_core_step),
        .mcand_i   (w_mag_a),
        .mplier_i  (w_mag_b),
        .product_o (w_core_prod),
        .cnt_o     (w_cnt)
    );

    always_comb begin
        state_d     = state_q;
        w_core_load = 1'b0;
        w_core_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    w_core_load = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                w_core_step = 1'b1;
                if (w_cnt == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_DONE);
            if (bus.load_a) begin
                op_a_q <= bus.din;
            end
            if (bus.load_b) begin
                op_b_q <= bus.din;
            end
            if (w_core_load) begin
                neg_q <= w_neg;
                if (!HOLD_RES) begin
                    result_q <= '0;
                end
            end
            if (state_q == S_DONE) begin
                result_q <= w_final;
            end
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.op_a   = op_a_q;
    assign bus.op_b   = op_b_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_mul_unit
// Brief    : Self-checking bench for seq_mul_unit at WIDTH=8/HOLD_RES=1 and WIDTH=16/HOLD_RES=0.
// Revision : 1.0
// ============================================================================
module tb_seq_mul_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_mul_unit_if #(.WIDTH(8))  if8 ();
    seq_mul_unit_if #(.WIDTH(16)) if16 ();

    seq_mul_unit #(.WIDTH(8), .HOLD_RES(1'b1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    seq_mul_unit #(.WIDTH(16), .HOLD_RES(1'b0)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          sgn;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Plain integer arithmetic on the operands as the mode interprets them.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int w, input bit sgn);
        longint sa, sb, p;
        logic [63:0] mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (64'sd1 << w);
        if (sgn && b[w-1]) sb = sb - (64'sd1 << w);
        p    = sa * sb;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic ld8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk); if8.din = a; if8.load_a = 1'b1;
        @(negedge clk); if8.load_a = 1'b0; if8.din = b; if8.load_b = 1'b1;
        @(negedge clk); if8.load_b = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge after done or after the bound expires.
    task automatic run8(input bit sgn, output logic [15:0] res, output int lat, output bit busy_ok);
        if8.start = 1'b1; if8.signed_md = sgn;
        @(posedge clk); #1;
        if8.start = 1'b0; if8.load_a = 1'b0; if8.load_b = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (lat < 40) begin
            @(posedge clk); lat++; #1;
            if (if8.done) break;
            if (!if8.busy) busy_ok = 1'b0;
        end
        res = if8.result;
        @(negedge clk);
    endtask

    task automatic ld16(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk); if16.din = a; if16.load_a = 1'b1;
        @(negedge clk); if16.load_a = 1'b0; if16.din = b; if16.load_b = 1'b1;
        @(negedge clk); if16.load_b = 1'b0;
    endtask

    task automatic run16(input bit sgn, output logic [31:0] res, output int lat, output bit zero_ok);
        if16.start = 1'b1; if16.signed_md = sgn;
        @(posedge clk); #1;
        if16.start = 1'b0;
        lat = 0; zero_ok = (if16.result == 32'd0);
        while (lat < 60) begin
            @(posedge clk); lat++; #1;
            if (if16.done) break;
            if (if16.result != 32'd0) zero_ok = 1'b0;
        end
        res = if16.result;
        @(negedge clk);
    endtask

    initial begin
        vec_t        vt[6];
        logic [15:0] r8;
        logic [31:0] r16;
        int          lat, pulses, gap;
        bit          bok;
        logic [7:0]  ra, rb;
        bit          rs;

        vt[0] = '{8'd20,  8'd23,  1'b0, 16'h01CC};
        vt[1] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1};
        vt[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vt[3] = '{8'h00,  8'h80,  1'b1, 16'h0000};
        vt[4] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
        vt[5] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};

        {if8.din, if8.load_a, if8.load_b, if8.start, if8.signed_md} = '0;
        {if16.din, if16.load_a, if16.load_b, if16.start, if16.signed_md} = '0;
        rst_n = 1'b0;
        #2;
        chk("reset_busy",   64'(if8.busy),   64'd0);
        chk("reset_done",   64'(if8.done),   64'd0);
        chk("reset_result", 64'(if8.result), 64'd0);
        chk("reset_op_a",   64'(if8.op_a),   64'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            ld8(vt[i].a, vt[i].b);
            run8(vt[i].sgn, r8, lat, bok);
            chk($sformatf("vec%0d_result", i), 64'(r8), 64'(vt[i].exp));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
            chk($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
        end

        @(posedge clk); #1;
        chk("done_one_cycle", 64'(if8.done), 64'd0);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            ld8(ra, rb);
            run8(rs, r8, lat, bok);
            chk($sformatf("rand%0d_%0h_%0h_s%0d", i, ra, rb, rs), 64'(r8), ref_mul(32'(ra), 32'(rb), 8, rs));
        end

        // A start pulse while RUN must not queue a second operation.
        ld8(8'd20, 8'd23);
        pulses = 0;
        if8.start = 1'b1; if8.signed_md = 1'b0;
        @(posedge clk); #1 if8.start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk); if8.start = (k == 3);
            @(posedge clk); #1;
            if (if8.done) pulses++;
        end
        @(negedge clk); if8.start = 1'b0;
        chk("run_start_ignored", 64'(pulses), 64'd1);

        // Operand written at the start edge is not used by that operation.
        ld8(8'd20, 8'd23);
        if8.din = 8'd7; if8.load_a = 1'b1;
        run8(1'b0, r8, lat, bok);
        chk("old_a_used", 64'(r8), 64'd460);
        chk("op_a_after", 64'(if8.op_a), 64'd7);

        // start held high: one completion every WIDTH+2 cycles.
        if8.start = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); lat++; #1;
            if (if8.done) break;
        end
        gap = 0;
        while (gap < 40) begin
            @(posedge clk); gap++; #1;
            if (if8.done) break;
        end
        chk("b2b_period", 64'(gap), 64'd10);
        chk("b2b_result", 64'(if8.result), 64'd161);
        @(negedge clk); if8.start = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset between edges in the middle of RUN.
        ld8(8'd20, 8'd23);
        if8.start = 1'b1;
        @(posedge clk); #1 if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy",   64'(if8.busy),   64'd0);
        chk("arst_done",   64'(if8.done),   64'd0);
        chk("arst_result", 64'(if8.result), 64'd0);
        chk("arst_op_b",   64'(if8.op_b),   64'd0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (if8.done) pulses++;
        end
        chk("arst_no_done", 64'(pulses), 64'd0);
        ld8(8'd20, 8'd23);
        run8(1'b0, r8, lat, bok);
        chk("arst_next_op", 64'(r8), 64'd460);

        // WIDTH=16, result cleared at start.
        ld16(16'd3, 16'd5);
        run16(1'b0, r16, lat, bok);
        chk("w16_prep", 64'(r16), 64'd15);
        ld16(16'hFFFF, 16'h0002);
        run16(1'b0, r16, lat, bok);
        chk("w16_result",  64'(r16), 64'h0001_FFFE);
        chk("w16_latency", 64'(lat), 64'd17);
        chk("w16_zeroed",  64'(bok), 64'd1);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a16, b16;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            ld16(a16, b16);
            run16(1'b1, r16, lat, bok);
            chk($sformatf("w16_rand%0d", i), 64'(r16), ref_mul(32'(a16), 32'(b16), 16, 1'b1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
